// File: rtl/vector_list_writer_pkg.sv
// Shared types and constants for the linked-list vector image writer.
// Node layout: link word at the node address, data word right after it.
package vnlp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WR_DATA,
        WR_LINK,
        DONE
    } state_t;

    localparam int LINK_OFS   = 0;
    localparam int DATA_OFS   = 1;
    localparam int NODE_WORDS = 2;
    localparam int NULL_PTR   = 0;

    // Largest list that fits both the count register and the memory above base.
    function automatic int max_nodes(input int len_bits, input int addr_width, input int base);
        longint by_len;
        longint by_addr;
        by_len  = (longint'(1) << len_bits) - 1;
        by_addr = ((longint'(1) << addr_width) - longint'(base)) / NODE_WORDS;
        return int'((by_len < by_addr) ? by_len : by_addr);
    endfunction

endpackage

// File: rtl/vector_list_writer.sv
// Builds a null-terminated linked list of two-word nodes in vector memory
// from a valid/ready element stream, then reports head address and length.
module vector_list_writer
    import vnlp_pkg::*;
#(
    parameter int word_size = 24,
    parameter int addr_bits = 9,
    parameter int len_size  = 8,
    parameter int base_addr = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 wr_en,
    output logic [addr_bits-1:0] wr_addr,
    output logic [word_size-1:0] wr_data,
    output logic [addr_bits-1:0] head,
    output logic [len_size-1:0]  len,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam logic [addr_bits-1:0] BASE    = addr_bits'(base_addr);
    localparam logic [len_size-1:0]  MAX_LEN = len_size'(max_nodes(len_size, addr_bits, base_addr));

    state_t               state_q, state_d;
    logic [addr_bits-1:0] ptr_q, ptr_d;
    logic                 last_q, last_d;
    logic                 in_ready_q, in_ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [addr_bits-1:0] wr_addr_q, wr_addr_d;
    logic [word_size-1:0] wr_data_q, wr_data_d;
    logic [addr_bits-1:0] head_q, head_d;
    logic [len_size-1:0]  len_q, len_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic                 end_after_data;
    logic                 end_now;

    // In WR_DATA the count has not yet been bumped; in WR_LINK it has.
    assign end_after_data = last_q || ((len_q + len_size'(1)) == MAX_LEN);
    assign end_now        = last_q || (len_q == MAX_LEN);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_d     = last_q;
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        head_d     = head_q;
        len_d      = len_q;
        busy_d     = busy_q;
        done_d     = done_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = ACCEPT;
                    ptr_d      = BASE;
                    len_d      = '0;
                    done_d     = 1'b0;
                    overflow_d = 1'b0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                end
            end
            ACCEPT: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    in_ready_d = 1'b0;
                    last_d     = in_last;
                    state_d    = WR_DATA;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = ptr_q + addr_bits'(DATA_OFS);
                    wr_data_d  = in_data;
                end
            end
            WR_DATA: begin
                state_d   = WR_LINK;
                len_d     = len_q + len_size'(1);
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_q + addr_bits'(LINK_OFS);
                wr_data_d = end_after_data ? word_size'(NULL_PTR)
                                           : word_size'(ptr_q + addr_bits'(NODE_WORDS));
            end
            WR_LINK: begin
                if (end_now) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    head_d     = BASE;
                    overflow_d = !last_q;
                end else begin
                    state_d    = ACCEPT;
                    ptr_d      = ptr_q + addr_bits'(NODE_WORDS);
                    in_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            head_q     <= '0;
            len_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            head_q     <= head_d;
            len_q      <= len_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign head     = head_q;
    assign len      = len_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_vector_list_writer.sv
// Directed bench: three writer configurations share one stream source;
// every memory write is logged and compared with a hand-derived node image.
module tb_vector_list_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;

    logic        ir [3];
    logic        we [3];
    logic [23:0] wd [3];
    logic [7:0]  ln [3];
    logic        by [3];
    logic        dn [3];
    logic        ov [3];
    logic [8:0]  wa0, wa1, hd0, hd1;
    logic [3:0]  wa2, hd2;

    always #5 clk = ~clk;

    vector_list_writer #(.word_size(24), .addr_bits(9), .len_size(8), .base_addr(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir[0]), .wr_en(we[0]), .wr_addr(wa0), .wr_data(wd[0]),
        .head(hd0), .len(ln[0]), .busy(by[0]), .done(dn[0]), .overflow(ov[0]));

    vector_list_writer #(.word_size(24), .addr_bits(9), .len_size(8), .base_addr(16)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir[1]), .wr_en(we[1]), .wr_addr(wa1), .wr_data(wd[1]),
        .head(hd1), .len(ln[1]), .busy(by[1]), .done(dn[1]), .overflow(ov[1]));

    vector_list_writer #(.word_size(24), .addr_bits(4), .len_size(8), .base_addr(0)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(ir[2]), .wr_en(we[2]), .wr_addr(wa2), .wr_data(wd[2]),
        .head(hd2), .len(ln[2]), .busy(by[2]), .done(dn[2]), .overflow(ov[2]));

    int          sel = 0;
    logic        m_ir, m_we, m_by, m_dn, m_ov;
    logic [8:0]  m_wa, m_hd;
    logic [23:0] m_wd;
    logic [7:0]  m_ln;

    always_comb begin
        m_ir = ir[sel]; m_we = we[sel]; m_wd = wd[sel]; m_ln = ln[sel];
        m_by = by[sel]; m_dn = dn[sel]; m_ov = ov[sel];
        case (sel)
            0:       begin m_wa = wa0;          m_hd = hd0;          end
            1:       begin m_wa = wa1;          m_hd = hd1;          end
            default: begin m_wa = {5'b0, wa2};  m_hd = {5'b0, hd2};  end
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q_addr[$];
    int q_data[$];
    int overlap = 0;
    always @(negedge clk) begin
        if (m_we) begin
            q_addr.push_back(int'(m_wa));
            q_data.push_back(int'(m_wd));
        end
        if (m_we && m_ir) overlap++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start(input int s);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    // st: 0 accepted, 1 refused because the list completed, 2 timed out
    task automatic send(input logic [23:0] d, input bit last, output int st, output int hc);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        st = 2;
        hc = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_ir) begin
                hc = cyc;
                st = 0;
                @(negedge clk);
                break;
            end
            if (m_dn) begin
                st = 1;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output int dc);
        ok = 0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (m_dn) begin
                ok = 1;
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_list(input string tag, input int base, input logic [9:0][23:0] d,
                            input int n, input int maxn);
        int acc;
        acc = (n < maxn) ? n : maxn;
        chk({tag, "_nwrites"}, q_addr.size(), 2 * acc);
        for (int k = 0; k < acc; k++) begin
            if (2 * k + 1 < q_addr.size()) begin
                chk({tag, "_data_addr"}, q_addr[2*k], base + 2*k + 1);
                chk({tag, "_data_val"},  q_data[2*k], int'(d[k]));
                chk({tag, "_link_addr"}, q_addr[2*k+1], base + 2*k);
                chk({tag, "_link_val"},  q_data[2*k+1], (k == acc - 1) ? 0 : base + 2*k + 2);
            end
        end
    endtask

    typedef struct {
        int              sel;
        int              n;
        logic [9:0][23:0] d;
        bit              last;
        int              gap;
        int              base;
        int              maxn;
        int              exp_len;
        bit              exp_ovf;
    } vec_t;

    vec_t vt[5];
    int   lit_a[6] = '{1, 0, 3, 2, 5, 4};
    int   lit_d[6] = '{5, 2, 'h00FFFF, 4, 'hABCDEF, 0};

    initial begin
        int st, hc, dc, acc_cnt;
        bit ok;
        logic [9:0][23:0] dd;

        vt[0] = '{sel: 0, n: 3, d: '0, last: 1, gap: 0, base: 0,  maxn: 255, exp_len: 3, exp_ovf: 0};
        vt[0].d[0] = 24'h5; vt[0].d[1] = 24'h00FFFF; vt[0].d[2] = 24'hABCDEF;
        vt[1] = '{sel: 1, n: 1, d: '0, last: 1, gap: 0, base: 16, maxn: 248, exp_len: 1, exp_ovf: 0};
        vt[1].d[0] = 24'h7;
        vt[2] = '{sel: 2, n: 10, d: '0, last: 0, gap: 0, base: 0, maxn: 8, exp_len: 8, exp_ovf: 1};
        for (int i = 0; i < 10; i++) vt[2].d[i] = 24'(i * 'h111 + 1);
        vt[3] = vt[0];
        vt[3].gap = 4;
        vt[4] = '{sel: 2, n: 8, d: '0, last: 1, gap: 0, base: 0, maxn: 8, exp_len: 8, exp_ovf: 0};
        for (int i = 0; i < 8; i++) vt[4].d[i] = 24'(i * 'h2020 + 3);

        repeat (2) @(negedge clk);
        chk("rst_wr_en", int'(we[0]), 0);
        chk("rst_in_ready", int'(ir[0]), 0);
        chk("rst_busy_done_ovf", int'({by[0], dn[0], ov[0]}), 0);
        chk("rst_addr_data", int'({wa0, wd[0]}), 0);
        chk("rst_head_len", int'({hd2, ln[2]}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            sel = vt[v].sel;
            @(negedge clk);
            q_addr.delete();
            q_data.delete();
            overlap = 0;
            pulse_start(sel);
            chk("start_clears", int'({m_dn, m_ov, m_ln}), 0);
            chk("start_busy_ready", int'({m_by, m_ir}), 3);
            acc_cnt = 0;
            hc = 0;
            for (int i = 0; i < vt[v].n; i++) begin
                send(vt[v].d[i], vt[v].last && (i == vt[v].n - 1), st, hc);
                if (st != 0) break;
                acc_cnt++;
                repeat (vt[v].gap) @(negedge clk);
            end
            wait_done(ok, dc);
            chk("done_seen", int'(ok), 1);
            if (v == 1) chk("done_latency", dc - hc, 3);
            chk("accepted", acc_cnt, vt[v].exp_len);
            chk("len", int'(m_ln), vt[v].exp_len);
            chk("overflow", int'(m_ov), int'(vt[v].exp_ovf));
            chk("head", int'(m_hd), vt[v].base);
            chk("busy_after", int'(m_by), 0);
            chk("no_write_while_ready", overlap, 0);
            chk_list("vec", vt[v].base, vt[v].d, vt[v].n, vt[v].maxn);
            repeat (3) @(negedge clk);
            chk("ready_after_done", int'(m_ir), 0);
            chk("done_held", int'(m_dn), 1);
            if (v == 0 && q_addr.size() == 6) begin
                for (int k = 0; k < 6; k++) begin
                    chk("lit_addr", q_addr[k], lit_a[k]);
                    chk("lit_data", q_data[k], lit_d[k]);
                end
            end
        end

        // Reset while the data word of the second element is on the bus
        sel = 0;
        pulse_start(0);
        send(24'h11, 1'b0, st, hc);
        send(24'h22, 1'b0, st, hc);
        chk("pre_rst_wr_en", int'(m_we), 1);
        chk("pre_rst_wr_addr", int'(m_wa), 3);
        rst = 1'b1;
        #1;
        chk("rst_mid_wr_en", int'(m_we), 0);
        chk("rst_mid_outputs", int'({m_by, m_dn, m_ov, m_ir, m_ln, m_wa, m_wd, m_hd}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q_addr.delete();
        q_data.delete();
        pulse_start(0);
        send(24'h33, 1'b0, st, hc);
        send(24'h44, 1'b1, st, hc);
        wait_done(ok, dc);
        chk("post_rst_done", int'(ok), 1);
        chk("post_rst_len", int'(m_ln), 2);
        dd = '0; dd[0] = 24'h33; dd[1] = 24'h44;
        chk_list("post_rst", 0, dd, 2, 255);

        // start while busy is ignored; start after done restarts cleanly
        @(negedge clk);
        q_addr.delete();
        q_data.delete();
        pulse_start(0);
        send(24'h55, 1'b0, st, hc);
        pulse_start(0);
        send(24'h66, 1'b1, st, hc);
        wait_done(ok, dc);
        chk("busy_start_done", int'(ok), 1);
        chk("busy_start_len", int'(m_ln), 2);
        dd = '0; dd[0] = 24'h55; dd[1] = 24'h66;
        chk_list("busy_start", 0, dd, 2, 255);
        pulse_start(0);
        chk("restart_clears", int'({m_dn, m_ov, m_ln}), 0);
        chk("restart_busy", int'({m_by, m_ir}), 3);
        send(24'h77, 1'b1, st, hc);
        wait_done(ok, dc);
        chk("restart_len", int'(m_ln), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/vector_list_writer.md
Name: vector_list_writer

Overview:
- Loader that builds, in the vector memory, the linked-list vector image that the norm processor later traverses.
- Accepts a stream of vector elements over a valid/ready handshake and lays them out as consecutive two-word nodes: link word, then data word.
- Terminates the list with a null link, then reports the head address and element count.
- Sits between the host/test source and the memory write port; it is the writer end of the processor's read path.

Parameters:
- word_size, 24, data word width (memory word width)
- addr_bits, 9, memory address width
- len_size, 8, element-count width
- base_addr, 0, address of the first node (must be even, < 2**addr_bits - 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin a new list; ignored unless busy=0
- in_data  in  word_size  element value
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies the final element; sampled with in_data
- in_ready  out  1  element accepted when in_valid&in_ready
- wr_en  out  1  memory write strobe
- wr_addr  out  addr_bits  memory write address
- wr_data  out  word_size  memory write data
- head  out  addr_bits  list head address (= base_addr) after done
- len  out  len_size  elements written
- busy  out  1  list build in progress
- done  out  1  list complete; held until next start or reset
- overflow  out  1  list truncated at capacity; held with done

Behaviour:
- Reset (async): state IDLE; in_ready, wr_en, busy, done, overflow = 0; wr_addr, wr_data, head, len = 0. wr_en drops in the same cycle rst asserts; no partial write survives reset.
- Capacity: MAX_NODES = min(2**len_size - 1, (2**addr_bits - base_addr)/2).
- Node k sits at N_k = base_addr + 2k. Link is written at N_k, data at N_k+1. NULL_PTR = 0. Links are zero-extended to word_size.
- FSM states:
  - IDLE: start -> ACCEPT; clear len, done, overflow; set busy; node pointer = base_addr.
  - ACCEPT: in_ready=1. On handshake, register in_data and in_last -> WR_DATA.
  - WR_DATA: wr_en=1, wr_addr=ptr+1, wr_data=element; len+1 -> WR_LINK.
  - WR_LINK: wr_en=1, wr_addr=ptr.
    - If last, or len==MAX_NODES: wr_data=NULL_PTR -> DONE.
    - Else: wr_data=ptr+2, ptr+=2 -> ACCEPT.
  - DONE: busy=0, done=1, head=base_addr. overflow=1 iff the list ended on capacity with in_last=0. start -> ACCEPT (same clears as IDLE).
- Throughput: one element per 3 cycles minimum. in_ready is low in WR_DATA, WR_LINK, IDLE and DONE.
- Backpressure: in_valid low in ACCEPT holds the state indefinitely; no writes occur.
- start while busy=1: ignored.
- Capacity hit with in_last=0: the element is written and the link is forced to NULL_PTR. Further stream data is not accepted (in_ready=0) until a new start.
- Capacity hit on the last element: overflow=0.
- Exactly one memory write per cycle; wr_en is never high in IDLE, ACCEPT or DONE.
- Pointer arithmetic is addr_bits wide; the capacity rule guarantees no wrap.

Decomposition:
- Package vnlp_pkg holds:
  - state enum (IDLE, ACCEPT, WR_DATA, WR_LINK, DONE)
  - LINK_OFS=0, DATA_OFS=1, NODE_WORDS=2, NULL_PTR=0
  - a function computing MAX_NODES from the parameters
- Single module; no sub-module. The FSM and the node-pointer/count registers are small enough to stay inline.

Test Plan:
- 3 elements {5, 0x00FFFF, 0xABCDEF}, base 0, last on the third -> writes (1,5), (0,2), (3,0x00FFFF), (2,4), (5,0xABCDEF), (4,0); len=3, done=1, overflow=0, head=0.
- Single element 7 with in_last, base_addr=16 -> writes (17,7), (16,0); len=1; done is asserted 3 cycles after the handshake.
- addr_bits=4, base 0 (MAX_NODES=8), 10 elements, no last -> 8 nodes written, node 7 link=0 at addr 14; len=8, overflow=1; in_ready=0 afterwards.
- in_valid toggled with 4-cycle gaps -> identical memory image to the gapless run; no wr_en during gaps.
- rst asserted during WR_DATA of element 2 -> wr_en=0 immediately; all outputs return to reset values; a new start then builds a correct list from base_addr.
- start pulsed while busy, then again after done -> the first is ignored; the second clears done, len and overflow next cycle and starts a new list.
